// File: rtl/alu_result_stage_if.sv
// Signal bundle between the ALU result stage, the ALU and the Z consumer.
// master is the stage itself; slave is the surrounding datapath.
interface alu_result_stage_if;
  logic        start;
  logic [3:0]  opcode_in;
  logic [63:0] alu_result;
  logic [3:0]  alu_opcode;
  logic        alu_exec;
  logic        busy;
  logic [31:0] zlo;
  logic [31:0] zhi;
  logic        z_valid;
  logic        z_ready;
  logic        lo_we;
  logic        hi_we;
  logic        illegal_op;

  modport master (
    input  start,
    input  opcode_in,
    input  alu_result,
    input  z_ready,
    output alu_opcode,
    output alu_exec,
    output busy,
    output zlo,
    output zhi,
    output z_valid,
    output lo_we,
    output hi_we,
    output illegal_op
  );

  modport slave (
    output start,
    output opcode_in,
    output alu_result,
    output z_ready,
    input  alu_opcode,
    input  alu_exec,
    input  busy,
    input  zlo,
    input  zhi,
    input  z_valid,
    input  lo_we,
    input  hi_we,
    input  illegal_op
  );
endinterface

// File: rtl/alu_result_stage.sv
// Sequences one ALU operation: exec, settle, capture into Z,
// then offer Z to the datapath until the consumer takes it.
module alu_result_stage #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input logic                clk,
  input logic                clr_n,
  alu_result_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPTURE,
    HOLD
  } state_t;

  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_DIV = 4'b1100;
  localparam logic [3:0] N_SET  = 4'(SETTLE_CYCLES);
  localparam logic [3:0] N_MD   = 4'(MULDIV_CYCLES);

  state_t      state;
  state_t      state_d;
  logic [3:0]  cnt;
  logic [3:0]  cnt_d;
  logic [3:0]  opc;
  logic [3:0]  opc_d;
  logic [31:0] zlo;
  logic [31:0] zlo_d;
  logic [31:0] zhi;
  logic [31:0] zhi_d;
  logic        zv;
  logic        zv_d;
  logic        we;
  logic        we_d;
  logic        ill;
  logic        ill_d;

  logic in_md;
  logic in_ill;
  logic cur_md;

  assign in_md  = (bus.opcode_in == OP_MUL) ||
                  (bus.opcode_in == OP_DIV);
  assign in_ill = bus.opcode_in > OP_DIV;
  assign cur_md = (opc == OP_MUL) || (opc == OP_DIV);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    opc_d   = opc;
    zlo_d   = zlo;
    zhi_d   = zhi;
    zv_d    = zv;
    we_d    = 1'b0;
    ill_d   = ill;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          opc_d = bus.opcode_in;
          ill_d = 1'b0;
          if (in_ill) begin
            state_d = HOLD;
            zlo_d   = '0;
            zhi_d   = '0;
            ill_d   = 1'b1;
            zv_d    = 1'b1;
          end else begin
            state_d = EXEC;
            cnt_d   = in_md ? N_MD : N_SET;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // single-width ops never carry a meaningful high word
        zlo_d   = bus.alu_result[31:0];
        zhi_d   = cur_md ? bus.alu_result[63:32] : '0;
        zv_d    = 1'b1;
        we_d    = cur_md;
        state_d = HOLD;
      end
      HOLD: begin
        if (zv && bus.z_ready) begin
          zv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
      cnt   <= '0;
      opc   <= '0;
      zlo   <= '0;
      zhi   <= '0;
      zv    <= 1'b0;
      we    <= 1'b0;
      ill   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      opc   <= opc_d;
      zlo   <= zlo_d;
      zhi   <= zhi_d;
      zv    <= zv_d;
      we    <= we_d;
      ill   <= ill_d;
    end
  end

  assign bus.alu_opcode = opc;
  assign bus.alu_exec   = (state == EXEC) ||
                          (state == CAPTURE);
  assign bus.busy       = state != IDLE;
  assign bus.zlo        = zlo;
  assign bus.zhi        = zhi;
  assign bus.z_valid    = zv;
  assign bus.lo_we      = we;
  assign bus.hi_we      = we;
  assign bus.illegal_op = ill;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: random ops against
// a reference model, with a decoupled Z monitor.
module tb_alu_result_stage;

  localparam int SET_N = 2;
  localparam int MD_N  = 4;

  typedef struct {
    logic [31:0] zhi;
    logic [31:0] zlo;
    logic        ill;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n;
  logic mon_on = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_result_stage_if bus();

  alu_result_stage #(
    .SETTLE_CYCLES(SET_N),
    .MULDIV_CYCLES(MD_N)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [63:0] res);
    exp_t e;
    e.ill = op >= 4'd13;
    e.we  = (op == 4'd11) || (op == 4'd12);
    e.zlo = e.ill ? 32'd0 : res[31:0];
    e.zhi = e.we ? res[63:32] : 32'd0;
    return e;
  endfunction

  function automatic int lat(input logic [3:0] op);
    if (op >= 4'd13) return 0;
    if (op == 4'd11 || op == 4'd12) return MD_N + 1;
    return SET_N + 1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_opc"}, bus.alu_opcode, 0);
    chk({tag, "_exec"}, bus.alu_exec, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_z"}, {bus.zhi, bus.zlo}, 0);
    chk({tag, "_zv"}, bus.z_valid, 0);
    chk({tag, "_we"}, {bus.lo_we, bus.hi_we}, 0);
    chk({tag, "_ill"}, bus.illegal_op, 0);
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [63:0] res,
                        input int hold);
    int   cyc = 0;
    int   execs = 0;
    exp_t e;
    e = model(op, res);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.opcode_in  = op;
    bus.alu_result = res;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.opcode_in = 4'($urandom);
    chk("alu_opcode", bus.alu_opcode, op);
    chk("busy_start", bus.busy, 1);
    forever begin
      @(negedge clk);
      if (bus.z_valid || cyc > 40) break;
      execs += int'(bus.alu_exec);
      bus.start     = 1'($urandom_range(0, 1));
      bus.z_ready   = 1'($urandom_range(0, 1));
      bus.opcode_in = 4'($urandom);
      @(posedge clk);
      cyc++;
    end
    chk("latency", cyc, lat(op));
    chk("exec_cycles", execs, lat(op));
    bus.alu_result = {$urandom, $urandom};
    bus.z_ready    = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("hold_valid", bus.z_valid, 1);
      chk("hold_busy", bus.busy, 1);
      chk("hold_exec", bus.alu_exec, 0);
      chk("hold_z", {bus.zhi, bus.zlo}, {e.zhi, e.zlo});
    end
    bus.z_ready = 1'b1;
    bus.start   = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bus.z_ready = 1'b0;
    bus.start   = 1'b0;
    chk("hs_valid", bus.z_valid, 0);
    chk("hs_busy", bus.busy, 0);
    chk("idle_z", {bus.zhi, bus.zlo}, {e.zhi, e.zlo});
  endtask

  task automatic reset_mid_div();
    @(negedge clk);
    bus.start      = 1'b1;
    bus.opcode_in  = 4'd12;
    bus.alu_result = {$urandom, $urandom};
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    chk_zero("rst_mid");
    @(posedge clk);
    #1;
    chk("rst_stay_idle", bus.busy, 0);
  endtask

  // monitor: pops on every new Z offer, polices the we strobes
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (bus.z_valid && !prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_z actual=%h required=none",
                   {bus.zhi, bus.zlo});
        end else begin
          e = sb.pop_front();
          chk("zlo", bus.zlo, e.zlo);
          chk("zhi", bus.zhi, e.zhi);
          chk("illegal_op", bus.illegal_op, e.ill);
          chk("lo_we", bus.lo_we, e.we);
          chk("hi_we", bus.hi_we, e.we);
        end
      end else begin
        chk("we_quiet", {bus.lo_we, bus.hi_we}, 0);
      end
      prev = bus.z_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n          = 1'b0;
    bus.start      = 1'b0;
    bus.opcode_in  = 4'd0;
    bus.alu_result = 64'd0;
    bus.z_ready    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset");
    clr_n  = 1'b1;
    mon_on = 1'b1;
    run_op(4'd0, 64'h0000_0000_0000_0007, 0);
    run_op(4'd11, 64'h0000_0001_FFFF_FFFE, 10);
    run_op(4'd14, 64'hDEAD_BEEF_1234_5678, 2);
    run_op(4'd3, 64'hCAFE_0000_0BAD_F00D, 1);
    reset_mid_div();
    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom_range(0, 15)),
             {$urandom, $urandom},
             $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
